// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller: SR/Cause/EPC/PRId, MEM-stage exception and interrupt
// sampling, pipeline flush request, mfc0/mtc0 access and eret support.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID_VALUE   = 32'h2019_0001,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  readAddr,
  input  logic [4:0]  writeAddr,
  input  logic [31:0] writeData,
  input  logic        writeEn,
  input  logic [31:0] PC,
  input  logic        isBD,
  input  logic [4:0]  excCode,
  input  logic        eret,
  input  logic [5:0]  HWInt,
  output logic [31:0] readData,
  output logic [31:0] EPCOut,
  output logic [31:0] handlerPC,
  output logic        req
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        take;
  logic [31:0] pc_aligned;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_req    = ie_q & ~exl_q & (|(HWInt & im_q));
  assign exc_req    = (excCode != 5'd0) & ~exl_q;
  assign take       = int_req | exc_req;
  // Reset must kill the flush even though excCode may still be presented.
  assign req        = ~reset & take;
  assign pc_aligned = {PC[31:2], 2'b00};

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (take) begin
      exl_d      = 1'b1;
      bd_d       = isBD;
      exc_code_d = int_req ? 5'd0 : excCode;
      epc_d      = isBD ? (pc_aligned - 32'd4) : pc_aligned;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (writeEn) begin
      case (writeAddr)
        5'd12: begin
          im_d  = writeData[15:10];
          exl_d = writeData[1];
          ie_d  = writeData[0];
        end
        5'd14:   epc_d = writeData;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= HWInt;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};

  always_comb begin
    readData = 32'd0;
    case (readAddr)
      5'd12:   readData = sr_word;
      5'd13:   readData = cause_word;
      5'd14:   readData = epc_q;
      5'd15:   readData = PRID_VALUE;
      default: readData = 32'd0;
    endcase
  end

  assign EPCOut    = epc_q;
  assign handlerPC = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed and randomized bench for cp0_exc_ctrl against a register-word reference model.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID    = 32'h2019_0001;
  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  readAddr, writeAddr, excCode;
  logic [31:0] writeData, PC;
  logic        writeEn, isBD, eret;
  logic [5:0]  HWInt;
  logic [31:0] readData, EPCOut, handlerPC;
  logic        req;

  int checks   = 0;
  int failures = 0;

  // Reference model holds the architectural register words directly.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .readAddr(readAddr), .writeAddr(writeAddr),
    .writeData(writeData), .writeEn(writeEn), .PC(PC), .isBD(isBD),
    .excCode(excCode), .eret(eret), .HWInt(HWInt), .readData(readData),
    .EPCOut(EPCOut), .handlerPC(handlerPC), .req(req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_int();
    return m_sr[0] & ~m_sr[1] & (|(HWInt & m_sr[15:10]));
  endfunction

  function automatic logic m_req();
    if (reset) return 1'b0;
    return m_int() | ((excCode != 5'd0) & ~m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_sr = 0; m_cause = 0; m_epc = 0;
  endtask

  task automatic model_edge();
    logic take, irq;
    logic [31:0] pca;
    if (reset) begin
      model_reset();
      return;
    end
    take = m_req();
    irq  = m_int();
    pca  = PC & ~32'h3;
    if (take) begin
      m_sr[1]     = 1'b1;
      m_cause[31] = isBD;
      m_cause[6:2] = irq ? 5'd0 : excCode;
      m_epc       = isBD ? pca - 32'd4 : pca;
    end else if (eret) begin
      m_sr[1] = 1'b0;
    end else if (writeEn) begin
      if (writeAddr == 5'd12) m_sr = writeData & 32'h0000_FC03;
      else if (writeAddr == 5'd14) m_epc = writeData;
    end
    m_cause[15:10] = HWInt;
  endtask

  task automatic peek(input logic [4:0] a, input string tag);
    readAddr = a;
    #1;
    chk(tag, readData, m_read(a));
  endtask

  // Checks outputs against the model, then advances one clock edge.
  task automatic tick(input string tag);
    #1;
    chk({tag, "_req"}, {31'd0, req}, {31'd0, m_req()});
    chk({tag, "_rd"}, readData, m_read(readAddr));
    chk({tag, "_epcout"}, EPCOut, m_epc);
    chk({tag, "_hpc"}, handlerPC, HANDLER);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    writeEn = 0; writeAddr = 0; writeData = 0; eret = 0; excCode = 0; isBD = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; model_reset();
    tick("rst");
    reset = 0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1; readAddr = 12; PC = 0; HWInt = 0;
    idle();
    model_reset();
    do_reset();

    // 1) exception with SR=0
    excCode = 5'd10; PC = 32'h3010;
    #1; chk("t1_req_now", {31'd0, req}, 32'd1);
    tick("t1a");
    peek(14, "t1_epc_m"); chk("t1_epc", readData, 32'h3010);
    peek(13, "t1_cause_m"); chk("t1_cause", readData, 32'h0000_0028);
    readAddr = 12;
    chk("t1_req_exl", {31'd0, req}, 32'd0);
    tick("t1b");

    // 5) reset asserted mid-handler, between edges
    excCode = 5'd10;
    reset = 1; model_reset();
    peek(12, "t5_sr"); chk("t5_sr0", readData, 32'd0);
    peek(13, "t5_cause");
    readAddr = 14;
    chk("t5_req0", {31'd0, req}, 32'd0);
    tick("t5");
    peek(15, "t5_prid"); chk("t5_prid_c", readData, PRID);
    reset = 0; idle();
    tick("t5_rel");

    // 2) mtc0 SR then interrupt in a delay slot
    writeEn = 1; writeAddr = 12; writeData = 32'h0000_0401; readAddr = 12;
    tick("t2_mtc0");
    idle();
    HWInt = 6'b000001; isBD = 1; PC = 32'h3024;
    #1; chk("t2_req_now", {31'd0, req}, 32'd1);
    tick("t2a");
    isBD = 0;
    peek(14, "t2_epc_m"); chk("t2_epc", readData, 32'h3020);
    peek(13, "t2_cause_m"); chk("t2_cause", readData, 32'h8000_0400);

    // 3) eret clears EXL; pending interrupt fires the following cycle
    eret = 1; readAddr = 12;
    tick("t3_eret");
    eret = 0;
    chk("t3_epc_kept", EPCOut, 32'h3020);
    chk("t3_req_again", {31'd0, req}, 32'd1);
    tick("t3_irq");

    // 4) mtc0 EPC loses to a same-cycle exception
    eret = 1; HWInt = 0;
    tick("t4_eret");
    eret = 0;
    writeEn = 1; writeAddr = 14; writeData = 32'h1234; excCode = 5'd4; PC = 32'h3000; isBD = 0;
    tick("t4_exc");
    idle();
    peek(14, "t4_epc_m"); chk("t4_epc", readData, 32'h3000);

    // 6) interrupt beats excCode 12; mtc0 to Cause ignored
    eret = 1;
    tick("t6_eret");
    eret = 0; HWInt = 6'b000001; excCode = 5'd12; PC = 32'h3100;
    tick("t6_both");
    idle();
    peek(13, "t6_cause_m"); chk("t6_exccode", {27'd0, readData[6:2]}, 32'd0);
    writeEn = 1; writeAddr = 13; writeData = 32'hFFFF_FFFF;
    tick("t6_mtc0");
    idle();
    peek(13, "t6_cause_after");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 60) == 0);
      if (reset) model_reset();
      HWInt     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      excCode   = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
      eret      = ($urandom_range(0, 5) == 0);
      writeEn   = ($urandom_range(0, 2) == 0);
      writeAddr = 5'($urandom_range(11, 16));
      writeData = $urandom;
      PC        = $urandom;
      isBD      = $urandom_range(0, 1);
      readAddr  = 5'($urandom_range(10, 17));
      tick("rnd");
      reset = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
